vuart_csr_bridge: RTL
=====================

# vuart_csr_bridge

AXI4-Lite slave that converts host MMIO accesses into the single-command CSR strobe interface of the virtual UART register block (`vuart_csr`). It sits directly upstream of that block.
- Writes are issued as one-cycle `csr_write` pulses.
- Reads are issued as a held `csr_read` level that is released when `csr_readdata_valid` returns.
- Only one transaction is in flight at a time, followed by a mandatory idle gap so the downstream edge detectors re-arm.

## Interface
Parameters:
- ADDR_WIDTH, ofs_fim_cfg_pkg::MMIO_ADDR_WIDTH, AXI address width
- DATA_WIDTH, 64, data width; only 64 is supported
- HI_ADDR_BIT, 8, top CSR address bit forwarded downstream
- GAP_CYCLES, 2, idle cycles after each completed transaction (minimum 2)
- TIMEOUT_CYCLES, 256, read watchdog limit (minimum 8)

Ports:
- clk_csr  in  1  CSR clock
- rst_n_csr  in  1  reset; asynchronous, active-low
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  ADDR_WIDTH  write byte address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  64  write data
- wstrb  in  8  byte strobes
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  write response: 0=OKAY, 2=SLVERR
- arvalid/arready  in/out  1  read address handshake
- araddr  in  ADDR_WIDTH  read byte address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  64  read data
- rresp  out  2  read response
- csr_write  out  1  one-cycle write strobe
- csr_waddr  out  HI_ADDR_BIT+1  write address
- csr_write_type  out  csr_access_type_t  UPPER32/LOWER32/FULL64
- csr_wdata  out  64  write data
- csr_wstrb  out  8  strobes, passed through
- csr_read  out  1  read request level
- csr_raddr  out  HI_ADDR_BIT+1  read address
- csr_readdata  in  64  read data from the CSR block
- csr_readdata_valid  in  1  read data valid, one-cycle pulse

## Operation
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP, GAP.
- IDLE:
  - awready and wready are asserted together, only when awvalid & wvalid and write is granted.
  - arready is asserted only when arvalid and read is granted.
  - When both are pending, the 1-bit round-robin chooses: the type not served last wins. It resets to favour write.
- Write decode from wstrb: 0xFF→FULL64, 0x0F→LOWER32, 0xF0→UPPER32.
- Write error: any other wstrb, or any nonzero awaddr bit above HI_ADDR_BIT, gives SLVERR. No csr_write is issued; the FSM goes straight to WR_RESP.
- WR_ISSUE: csr_write=1 for exactly one cycle with address, data, type and strobes registered. Then WR_RESP.
- WR_RESP: bvalid held until bready, then GAP.
- Read error: a nonzero araddr bit above HI_ADDR_BIT gives rresp=SLVERR with rdata=0. No csr_read is issued; the FSM goes to RD_RESP.
- RD_WAIT:
  - csr_read=1 and csr_raddr are held stable.
  - On csr_readdata_valid, rdata is captured and csr_read deasserts the next cycle. Then RD_RESP.
- RD_RESP: rvalid held until rready; rdata/rresp stable. Then GAP.
- GAP: counts GAP_CYCLES, then returns to IDLE.
- csr_readdata_valid outside RD_WAIT is ignored. This covers a late return after a timeout.
- Reset values: all valid/ready/strobe outputs 0, addresses/data 0, bresp/rresp 0, csr_write_type FULL64, FSM IDLE, round-robin favours write.
- Reset asserted mid-transaction returns the FSM to IDLE immediately, drops csr_read/bvalid/rvalid, and loses the transaction.

## Timing
- AW/W or AR handshake at cycle T.
- Write: csr_write at T+1; bvalid at T+2 (or T+1 on an error).
- Read: csr_read high from T+1. With the 5-cycle CSR block latency, csr_readdata_valid arrives at T+6, rvalid at T+7, and csr_read is low at T+7.
- Next IDLE acceptance is no earlier than GAP_CYCLES cycles after the B or R handshake.
- A ready may depend combinationally on its valid; no valid depends on a ready.

## Configuration
- VUART_CSR_BRIDGE_TIMEOUT_EN defined:
  - A watchdog counts RD_WAIT cycles.
  - On reaching TIMEOUT_CYCLES, csr_read drops, rdata=64'hDEAD_BEEF_DEAD_BEEF, rresp=SLVERR, and the FSM goes to RD_RESP.
- Undefined: RD_WAIT waits indefinitely; rresp is always OKAY for in-range reads.

## Structure
- Package vuart_csr_bridge_pkg holds:
  - state enum
  - RESP_OKAY/RESP_SLVERR constants
  - TIMEOUT_RDATA constant
  - wstrb-to-csr_access_type_t decode function
- csr_access_type_t is imported from ofs_csr_pkg.
- One sub-module, vuart_csr_bridge_wdog: a load/clear/expire counter, instantiated only under the macro.

## Test plan
- Write awaddr=0x18, wdata=0x1122334455667788, wstrb=0xFF → csr_write pulse at T+1 with csr_waddr=0x18 and FULL64; bvalid at T+2 with OKAY.
- Write wstrb=0xF0, then a separate write with wstrb=0x3C → first gives UPPER32 and OKAY; second gives no csr_write and bresp=SLVERR.
- Read araddr=0x20 with the CSR model returning 0xABCD after 5 cycles → csr_read held T+1..T+6, rvalid at T+7 with rdata=0xABCD, no second read edge.
- awvalid, wvalid and arvalid all asserted in the same cycle, twice in a row → write served first, read second, with ≥2 idle cycles between them.
- Timeout build with a CSR model that never responds, TIMEOUT_CYCLES=16 → rvalid with 0xDEADBEEFDEADBEEF and SLVERR; a late valid pulse is ignored.
- rst_n_csr asserted in RD_WAIT → csr_read=0 and rvalid=0 immediately; a new read after reset completes normally.

Source files
------------

// File: rtl/ofs_csr_pkg.sv
// ofs_csr_pkg
// Common CSR access types used by the strobe-style CSR blocks.
package ofs_csr_pkg;

    // Width of a CSR write as seen by the register block.
    typedef enum logic [1:0] {
        FULL64  = 2'b00,
        LOWER32 = 2'b01,
        UPPER32 = 2'b10
    } csr_access_type_t;

endpackage : ofs_csr_pkg

// File: rtl/ofs_fim_cfg_pkg.sv
// ofs_fim_cfg_pkg
// Platform configuration constants shared by FIM blocks. Only the MMIO address
// width is needed by the vUART CSR bridge.
package ofs_fim_cfg_pkg;

    localparam int MMIO_ADDR_WIDTH = 18;

endpackage : ofs_fim_cfg_pkg

// File: rtl/vuart_csr_bridge_pkg.sv
// vuart_csr_bridge_pkg
// Types and constants for the AXI4-Lite to vUART CSR strobe bridge:
// FSM state encoding, AXI response codes, the read-timeout data pattern and the
// byte-strobe to access-type decode.
package vuart_csr_bridge_pkg;

    import ofs_csr_pkg::*;

    // FSM state type and encodings.
    typedef logic [2:0] bridge_state_t;

    localparam bridge_state_t StIdle    = 3'd0;
    localparam bridge_state_t StWrIssue = 3'd1;
    localparam bridge_state_t StWrResp  = 3'd2;
    localparam bridge_state_t StRdWait  = 3'd3;
    localparam bridge_state_t StRdResp  = 3'd4;
    localparam bridge_state_t StGap     = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [63:0] TIMEOUT_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct packed {
        logic             ok;
        csr_access_type_t acc;
    } wstrb_dec_t;

    // Only whole 32-bit halves or the full 64-bit word are legal writes.
    function automatic wstrb_dec_t decode_wstrb(input logic [7:0] wstrb);
        wstrb_dec_t dec;
        dec.ok  = 1'b1;
        dec.acc = FULL64;
        case (wstrb)
            8'hFF:   dec.acc = FULL64;
            8'h0F:   dec.acc = LOWER32;
            8'hF0:   dec.acc = UPPER32;
            default: dec.ok  = 1'b0;
        endcase
        return dec;
    endfunction

endpackage : vuart_csr_bridge_pkg

// File: rtl/vuart_csr_bridge_wdog.sv
// vuart_csr_bridge_wdog
// Read watchdog: counts cycles after a load until either cleared or LIMIT cycles
// have elapsed, at which point expire is asserted for one cycle.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        start counting from zero
//   clear       stop counting (response arrived)
//   expire      high during the LIMIT-th counted cycle
module vuart_csr_bridge_wdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic          active_q;

    assign expire = active_q && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (clear || expire) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule : vuart_csr_bridge_wdog

// File: rtl/vuart_csr_bridge.sv
// vuart_csr_bridge
// AXI4-Lite slave that turns host MMIO accesses into the vuart_csr strobe
// interface: a one-cycle csr_write pulse per write, a held csr_read level per
// read (released once csr_readdata_valid returns). One transaction at a time,
// followed by GAP_CYCLES idle cycles so the downstream edge detectors re-arm.
// Ports:
//   clk_csr, rst_n_csr           clock, asynchronous active-low reset
//   aw*/w*/b*                    AXI4-Lite write channels
//   ar*/r*                       AXI4-Lite read channels
//   csr_write/waddr/wdata/...    write strobe interface to vuart_csr
//   csr_read/raddr               read request level and address
//   csr_readdata(_valid)         read return from vuart_csr
// Optional feature: define VUART_CSR_BRIDGE_TIMEOUT_EN to enable the read
// watchdog (TIMEOUT_CYCLES) that ends a stuck read with SLVERR.
module vuart_csr_bridge
    import ofs_csr_pkg::*;
    import vuart_csr_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = ofs_fim_cfg_pkg::MMIO_ADDR_WIDTH,
    parameter int DATA_WIDTH     = 64,  // only 64 is supported
    parameter int HI_ADDR_BIT    = 8,
    parameter int GAP_CYCLES     = 2,   // minimum 2
    parameter int TIMEOUT_CYCLES = 256  // minimum 8
) (
    input  logic                    clk_csr,
    input  logic                    rst_n_csr,

    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,

    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,

    output logic                    csr_write,
    output logic [HI_ADDR_BIT:0]    csr_waddr,
    output csr_access_type_t        csr_write_type,
    output logic [DATA_WIDTH-1:0]   csr_wdata,
    output logic [DATA_WIDTH/8-1:0] csr_wstrb,
    output logic                    csr_read,
    output logic [HI_ADDR_BIT:0]    csr_raddr,
    input  logic [DATA_WIDTH-1:0]   csr_readdata,
    input  logic                    csr_readdata_valid
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    bridge_state_t          state_q, state_d;
    logic                   favour_rd_q;  // round-robin: 1 = read wins a tie
    logic [GW-1:0]          gap_cnt_q;
    logic [1:0]             bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [HI_ADDR_BIT:0]   csr_waddr_q, csr_raddr_q;
    logic [DATA_WIDTH-1:0]  csr_wdata_q;
    logic [DATA_WIDTH/8-1:0] csr_wstrb_q;
    csr_access_type_t       csr_write_type_q;

    logic       wr_pend, grant_wr, grant_rd;
    logic       wr_err, rd_err, gap_done, rd_timeout;
    wstrb_dec_t wdec;

    always_comb begin
        wr_pend  = awvalid & wvalid;
        grant_wr = (state_q == StIdle) & wr_pend & (~arvalid | ~favour_rd_q);
        grant_rd = (state_q == StIdle) & arvalid & (~wr_pend | favour_rd_q);
        wdec     = decode_wstrb(wstrb);
        wr_err   = ~wdec.ok | (|awaddr[ADDR_WIDTH-1:HI_ADDR_BIT+1]);
        rd_err   = |araddr[ADDR_WIDTH-1:HI_ADDR_BIT+1];
        gap_done = (gap_cnt_q == GW'(GAP_CYCLES - 1));
    end

`ifdef VUART_CSR_BRIDGE_TIMEOUT_EN
    vuart_csr_bridge_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk_csr),
        .rst_n  (rst_n_csr),
        .load   (grant_rd & ~rd_err),
        .clear  ((state_q == StRdWait) & csr_readdata_valid),
        .expire (rd_timeout)
    );
`else
    // Without the watchdog a read waits forever; TIMEOUT_CYCLES is never zero.
    assign rd_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_wr)      state_d = wr_err ? StWrResp : StWrIssue;
                else if (grant_rd) state_d = rd_err ? StRdResp : StRdWait;
            end
            StWrIssue: state_d = StWrResp;
            StWrResp:  if (bready) state_d = StGap;
            StRdWait:  if (csr_readdata_valid || rd_timeout) state_d = StRdResp;
            StRdResp:  if (rready) state_d = StGap;
            StGap:     if (gap_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_csr or negedge rst_n_csr) begin
        if (!rst_n_csr) begin
            state_q          <= StIdle;
            favour_rd_q      <= 1'b0;
            gap_cnt_q        <= '0;
            bresp_q          <= RESP_OKAY;
            rresp_q          <= RESP_OKAY;
            rdata_q          <= '0;
            csr_waddr_q      <= '0;
            csr_raddr_q      <= '0;
            csr_wdata_q      <= '0;
            csr_wstrb_q      <= '0;
            csr_write_type_q <= FULL64;
        end else begin
            state_q <= state_d;

            if (state_q == StGap) gap_cnt_q <= gap_cnt_q + 1'b1;
            else                  gap_cnt_q <= '0;

            if (grant_wr) begin
                favour_rd_q <= 1'b1;
                if (wr_err) begin
                    bresp_q <= RESP_SLVERR;
                end else begin
                    bresp_q          <= RESP_OKAY;
                    csr_waddr_q      <= awaddr[HI_ADDR_BIT:0];
                    csr_wdata_q      <= wdata;
                    csr_wstrb_q      <= wstrb;
                    csr_write_type_q <= wdec.acc;
                end
            end

            if (grant_rd) begin
                favour_rd_q <= 1'b0;
                if (rd_err) begin
                    rresp_q <= RESP_SLVERR;
                    rdata_q <= '0;
                end else begin
                    csr_raddr_q <= araddr[HI_ADDR_BIT:0];
                end
            end

            // Returns outside RD_WAIT (e.g. after a timeout) are dropped.
            if (state_q == StRdWait) begin
                if (csr_readdata_valid) begin
                    rdata_q <= csr_readdata;
                    rresp_q <= RESP_OKAY;
                end else if (rd_timeout) begin
                    rdata_q <= TIMEOUT_RDATA;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end

    // Strobes and valids decode straight from state so reset drops them at once.
    assign awready        = grant_wr;
    assign wready         = grant_wr;
    assign arready        = grant_rd;
    assign bvalid         = (state_q == StWrResp);
    assign rvalid         = (state_q == StRdResp);
    assign csr_write      = (state_q == StWrIssue);
    assign csr_read       = (state_q == StRdWait);
    assign bresp          = bresp_q;
    assign rresp          = rresp_q;
    assign rdata          = rdata_q;
    assign csr_waddr      = csr_waddr_q;
    assign csr_raddr      = csr_raddr_q;
    assign csr_wdata      = csr_wdata_q;
    assign csr_wstrb      = csr_wstrb_q;
    assign csr_write_type = csr_write_type_q;

endmodule : vuart_csr_bridge
